// File: rtl/correlation_cell.sv
// One processing element of the systolic template-matching correlator: registers I*I,
// every T[k]*I and a copy of I for the next cell, all with the same single-cycle latency.
module correlation_cell #(
  parameter int PIXEL_SIZE    = 8,
  parameter int NUM_TEMPLATES = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [PIXEL_SIZE-1:0]     I,
  input  logic [PIXEL_SIZE-1:0]     T [NUM_TEMPLATES],
  output logic [PIXEL_SIZE-1:0]     I_out,
  output logic [2*PIXEL_SIZE-1:0]   I_square_out,
  output logic [2*PIXEL_SIZE-1:0]   T_x_I_out [NUM_TEMPLATES]
);

  localparam int PROD_W = 2 * PIXEL_SIZE;

  // Operands are zero-extended so the product is full precision and unsigned.
  function automatic logic [PROD_W-1:0] umul(input logic [PIXEL_SIZE-1:0] a,
                                             input logic [PIXEL_SIZE-1:0] b);
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    a_ext = {{PIXEL_SIZE{1'b0}}, a};
    b_ext = {{PIXEL_SIZE{1'b0}}, b};
    return a_ext * b_ext;
  endfunction

  logic [PROD_W-1:0] square_p0;
  logic [PROD_W-1:0] prod_p0 [NUM_TEMPLATES];

  // Stage 0: one dedicated multiplier per template lane plus the squarer.
  assign square_p0 = umul(I, I);

  for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_lane
    assign prod_p0[k] = umul(T[k], I);
  end

  // Stage 1: output registers; reset clears the whole result set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      I_out        <= '0;
      I_square_out <= '0;
      for (int k = 0; k < NUM_TEMPLATES; k++) begin
        T_x_I_out[k] <= '0;
      end
    end else begin
      I_out        <= I;
      I_square_out <= square_p0;
      for (int k = 0; k < NUM_TEMPLATES; k++) begin
        T_x_I_out[k] <= prod_p0[k];
      end
    end
  end

endmodule

// File: tb/tb_correlation_cell.sv
// Directed and random bench for correlation_cell: expectations are queued when inputs
// are driven and compared one edge later against the registered outputs.
module tb_correlation_cell;

  localparam int PW = 8;
  localparam int NT = 10;

  typedef struct packed {
    logic [PW-1:0]            i;
    logic [2*PW-1:0]          sq;
    logic [NT-1:0][2*PW-1:0]  tx;
  } exp_t;

  logic                CLK;
  logic                RST;
  logic [PW-1:0]       I;
  logic [PW-1:0]       T [NT];
  logic [PW-1:0]       I_out;
  logic [2*PW-1:0]     I_square_out;
  logic [2*PW-1:0]     T_x_I_out [NT];

  exp_t sb [$];
  int   tests;
  int   fails;

  correlation_cell #(.PIXEL_SIZE(PW), .NUM_TEMPLATES(NT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .I            (I),
    .T            (T),
    .I_out        (I_out),
    .I_square_out (I_square_out),
    .T_x_I_out    (T_x_I_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cmp(input string tag, input logic [2*PW-1:0] obs, input logic [2*PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one input set, queue the reference result, clock it and check one edge later.
  task automatic cycle(input logic rst, input logic [PW-1:0] i, input logic [NT-1:0][PW-1:0] t,
                       input string tag);
    exp_t e;
    int   p;
    RST = rst;
    I   = i;
    for (int k = 0; k < NT; k++) T[k] = t[k];
    e.i  = rst ? '0 : i;
    p    = int'(i) * int'(i);
    e.sq = rst ? '0 : p[2*PW-1:0];
    for (int k = 0; k < NT; k++) begin
      p        = int'(t[k]) * int'(i);
      e.tx[k]  = rst ? '0 : p[2*PW-1:0];
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
    end else begin
      e = sb.pop_front();
      cmp({tag, ".i_out"}, {{PW{1'b0}}, I_out}, {{PW{1'b0}}, e.i});
      cmp({tag, ".sq"}, I_square_out, e.sq);
      for (int k = 0; k < NT; k++) cmp($sformatf("%s.tx%0d", tag, k), T_x_I_out[k], e.tx[k]);
    end
  endtask

  function automatic logic [NT-1:0][PW-1:0] fill(input logic [PW-1:0] v);
    logic [NT-1:0][PW-1:0] r;
    for (int k = 0; k < NT; k++) r[k] = v;
    return r;
  endfunction

  function automatic logic [NT-1:0][PW-1:0] rnd_t();
    logic [NT-1:0][PW-1:0] r;
    for (int k = 0; k < NT; k++) r[k] = PW'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    logic [NT-1:0][PW-1:0] tv;
    tests = 0;
    fails = 0;
    RST = 1'b1;
    I   = '0;
    for (int k = 0; k < NT; k++) T[k] = '0;
    @(negedge CLK);

    // Reset held two edges with nonzero inputs, then release.
    cycle(1'b1, 8'd200, fill(8'd200), "rst0");
    cycle(1'b1, 8'd200, fill(8'd200), "rst1");
    cycle(1'b0, 8'd200, fill(8'd200), "rel");

    // Lane independence.
    for (int k = 0; k < NT; k++) tv[k] = PW'(k);
    cycle(1'b0, 8'd3, tv, "lane");

    // Extremes.
    cycle(1'b0, 8'd255, fill(8'd255), "max");
    cycle(1'b0, 8'd0, rnd_t(), "izero");
    for (int k = 0; k < NT; k++) tv[k] = (k % 2 == 0) ? 8'd0 : 8'd255;
    cycle(1'b0, 8'd255, tv, "tzero");

    // Back-to-back latency.
    cycle(1'b0, 8'd10, fill(8'd1), "b2b10");
    cycle(1'b0, 8'd20, fill(8'd2), "b2b20");
    cycle(1'b0, 8'd30, fill(8'd3), "b2b30");

    // Mid-stream reset for a single edge.
    for (int n = 0; n < 5; n++) cycle(1'b0, PW'($urandom_range(0, 255)), rnd_t(), "pre");
    cycle(1'b1, PW'($urandom_range(1, 255)), rnd_t(), "midrst");
    for (int n = 0; n < 5; n++) cycle(1'b0, PW'($urandom_range(0, 255)), rnd_t(), "post");

    // Random traffic; a decoy value is applied between edges and overwritten before the edge.
    for (int n = 0; n < 1000; n++) begin
      #($urandom_range(0, 3));
      I = PW'($urandom_range(0, 255));
      for (int k = 0; k < NT; k++) T[k] = PW'($urandom_range(0, 255));
      #($urandom_range(1, 4));
      cycle(1'b0, PW'($urandom_range(0, 255)), rnd_t(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
